// File: rtl/atomic_counter_param_if.sv
// atomic_counter_param_if: event/read handshake bundle for atomic_counter_param
// master drives trig_i/clr_i/req_i/atomic_i; slave returns ack_o/count_o/beat_o/last_o/ovf_o
interface atomic_counter_param_if #(
   parameter int BUS_W  = 32,
   parameter int BEAT_W = 1
);
   logic              trig_i, clr_i, req_i, atomic_i;
   logic              ack_o, last_o, ovf_o;
   logic [BUS_W-1:0]  count_o;
   logic [BEAT_W-1:0] beat_o;
   modport master (output trig_i, clr_i, req_i, atomic_i, input ack_o, count_o, beat_o, last_o, ovf_o);
   modport slave  (input trig_i, clr_i, req_i, atomic_i, output ack_o, count_o, beat_o, last_o, ovf_o);
endinterface

// File: rtl/atomic_counter_param.sv
// atomic_counter_param: free-running COUNT_W event counter read coherently over a BUS_W bus in beats
// ports: clk, rst (sync, active-high); bus.slave carries trig/clr/req/atomic in and ack/count/beat/last/ovf out
module atomic_counter_param #(
   parameter int COUNT_W  = 64,
   parameter int BUS_W    = 32,
   parameter int SATURATE = 0
) (
   input logic clk,
   input logic rst,
   atomic_counter_param_if.slave bus
);
   localparam int BEATS  = COUNT_W / BUS_W;
   localparam int BEAT_W = BEATS > 2 ? $clog2(BEATS) : 1;
   generate
      if (BEATS < 2 || COUNT_W % BUS_W != 0) begin : g_bad_params
         $error("atomic_counter_param: COUNT_W must be a multiple of BUS_W with at least 2 beats");
      end
   endgenerate
   typedef enum logic {IDLE, BUSY} state_t;
   state_t                       state, state_n;
   logic [COUNT_W-1:0]           cnt;
   logic [BEATS-1:0][BUS_W-1:0]  snap, snap_n;
   logic [BEAT_W-1:0]            idx, idx_n, beat_n;
   logic [BUS_W-1:0]             dat_n;
   logic                         last_n, top;
   assign top = idx == BEAT_W'(BEATS - 1);
   // beat 0 of an atomic read comes from the live counter, which equals the snapshot being taken
   always_comb begin
      state_n = state;
      idx_n   = idx;
      snap_n  = snap;
      dat_n   = '0;
      beat_n  = '0;
      last_n  = 1'b0;
      if (bus.req_i && bus.atomic_i) begin
         snap_n  = cnt;
         dat_n   = cnt[BUS_W-1:0];
         idx_n   = BEAT_W'(1);
         state_n = BUSY;
      end else if (bus.req_i && state == BUSY) begin
         dat_n   = snap[idx];
         beat_n  = idx;
         last_n  = top;
         idx_n   = top ? '0 : idx + BEAT_W'(1);
         state_n = top ? IDLE : BUSY;
      end else if (bus.req_i) begin
         dat_n   = cnt[BUS_W-1:0];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         snap        <= '0;
         cnt         <= '0;
         bus.ovf_o   <= 1'b0;
         bus.ack_o   <= 1'b0;
         bus.count_o <= '0;
         bus.beat_o  <= '0;
         bus.last_o  <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         snap        <= snap_n;
         cnt         <= bus.clr_i ? '0 : !bus.trig_i ? cnt : (&cnt && SATURATE != 0) ? cnt : cnt + COUNT_W'(1);
         bus.ovf_o   <= !bus.clr_i && (bus.ovf_o || (bus.trig_i && &cnt));
         bus.ack_o   <= bus.req_i;
         bus.count_o <= dat_n;
         bus.beat_o  <= beat_n;
         bus.last_o  <= last_n;
      end
   end
endmodule

// File: tb/tb_atomic_counter_param.sv
// tb_atomic_counter_param: three configurations (64/32 wrap, 8/4 wrap, 8/4 saturate) checked against an arithmetic model
module tb_atomic_counter_param;
   logic clk = 1'b0;
   logic rst, trig, clr, req, atomic;
   int   vectors = 0;
   int   miscompares = 0;
   always #5 clk = ~clk;
   atomic_counter_param_if #(.BUS_W(32), .BEAT_W(1)) ia ();
   atomic_counter_param_if #(.BUS_W(4),  .BEAT_W(1)) ib ();
   atomic_counter_param_if #(.BUS_W(4),  .BEAT_W(1)) ic ();
   assign ia.trig_i = trig; assign ia.clr_i = clr; assign ia.req_i = req; assign ia.atomic_i = atomic;
   assign ib.trig_i = trig; assign ib.clr_i = clr; assign ib.req_i = req; assign ib.atomic_i = atomic;
   assign ic.trig_i = trig; assign ic.clr_i = clr; assign ic.req_i = req; assign ic.atomic_i = atomic;
   atomic_counter_param #(.COUNT_W(64), .BUS_W(32), .SATURATE(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   atomic_counter_param #(.COUNT_W(8),  .BUS_W(4),  .SATURATE(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   atomic_counter_param #(.COUNT_W(8),  .BUS_W(4),  .SATURATE(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));
   int         cw  [3] = '{64, 8, 8};
   int         bw  [3] = '{32, 4, 4};
   int         sat [3] = '{0, 0, 1};
   logic [63:0] m_cnt [3], m_snap [3], e_val [3];
   logic        m_ovf [3], m_busy [3], e_ack [3], e_last [3];
   int          m_next [3], e_beat [3];
   function automatic logic [63:0] full(int k);
      return cw[k] == 64 ? '1 : (64'd1 << cw[k]) - 64'd1;
   endfunction
   function automatic logic [63:0] beat_of(logic [63:0] v, int b, int w);
      return (v >> (b * w)) & ((64'd1 << w) - 64'd1);
   endfunction
   task automatic model(int k, logic r, logic t, logic c, logic q, logic a);
      int beats;
      beats = cw[k] / bw[k];
      e_ack[k] = 0; e_val[k] = 0; e_beat[k] = 0; e_last[k] = 0;
      if (r) begin
         m_cnt[k] = 0; m_snap[k] = 0; m_ovf[k] = 0; m_busy[k] = 0; m_next[k] = 0;
         return;
      end
      if (q) begin
         e_ack[k] = 1;
         if (a) begin
            m_snap[k] = m_cnt[k];
            e_val[k]  = beat_of(m_cnt[k], 0, bw[k]);
            m_busy[k] = 1; m_next[k] = 1;
         end else if (m_busy[k]) begin
            e_val[k]  = beat_of(m_snap[k], m_next[k], bw[k]);
            e_beat[k] = m_next[k];
            e_last[k] = m_next[k] == beats - 1;
            m_next[k] = e_last[k] ? 0 : m_next[k] + 1;
            m_busy[k] = !e_last[k];
         end else begin
            e_val[k]  = beat_of(m_cnt[k], 0, bw[k]);
         end
      end
      if (c) begin
         m_cnt[k] = 0; m_ovf[k] = 0;
      end else if (t) begin
         if (m_cnt[k] == full(k)) begin
            m_ovf[k] = 1;
            m_cnt[k] = sat[k] != 0 ? full(k) : 64'd0;
         end else m_cnt[k] = m_cnt[k] + 64'd1;
      end
   endtask
   task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[dut%0d] @%0t: got %h expected %h", tag, k, $time, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("ack",   0, 64'(ia.ack_o),   64'(e_ack[0]));
      chk("count", 0, 64'(ia.count_o), e_val[0]);
      chk("beat",  0, 64'(ia.beat_o),  64'(e_beat[0]));
      chk("last",  0, 64'(ia.last_o),  64'(e_last[0]));
      chk("ovf",   0, 64'(ia.ovf_o),   64'(m_ovf[0]));
      chk("ack",   1, 64'(ib.ack_o),   64'(e_ack[1]));
      chk("count", 1, 64'(ib.count_o), e_val[1]);
      chk("beat",  1, 64'(ib.beat_o),  64'(e_beat[1]));
      chk("last",  1, 64'(ib.last_o),  64'(e_last[1]));
      chk("ovf",   1, 64'(ib.ovf_o),   64'(m_ovf[1]));
      chk("ack",   2, 64'(ic.ack_o),   64'(e_ack[2]));
      chk("count", 2, 64'(ic.count_o), e_val[2]);
      chk("beat",  2, 64'(ic.beat_o),  64'(e_beat[2]));
      chk("last",  2, 64'(ic.last_o),  64'(e_last[2]));
      chk("ovf",   2, 64'(ic.ovf_o),   64'(m_ovf[2]));
   endtask
   task automatic step(logic r, logic t, logic c, logic q, logic a);
      rst = r; trig = t; clr = c; req = q; atomic = a;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model(k, r, t, c, q, a);
      #1;
      check_all();
   endtask
   initial begin
      rst = 1; trig = 0; clr = 0; req = 0; atomic = 0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 1);
      step(0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 256; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(255) == 0, $urandom_range(1), $urandom_range(63) == 0,
              $urandom_range(1), $urandom_range(3) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/atomic_counter_param.md
Name: atomic_counter_param

Overview:
- Parametrised successor to the 64-bit atomic counter with a 32-bit read bus.
- Free-running event counter of generic width COUNT_W, read over a narrower BUS_W bus in BEATS = COUNT_W/BUS_W beats.
- An atomic read snapshots the whole counter in one cycle, so all beats are coherent while counting continues.
- Adds synchronous clear, a wrap/saturate mode, a sticky overflow flag, and beat index/last-beat outputs. Sits beside the block's register interface as a performance/event counter.

Parameters:
- COUNT_W, 64, counter width in bits; must be an integer multiple of BUS_W.
- BUS_W, 32, read bus width in bits.
- SATURATE, 0, 0 = wrap to zero on overflow; 1 = hold at all-ones.
- BEATS, COUNT_W/BUS_W (derived localparam), beats per full read; must be >= 2, else fail elaboration.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- trig_i  in  1  count event; +1 per cycle high.
- clr_i  in  1  synchronous clear of counter and ovf_o.
- req_i  in  1  read request, one beat per cycle high.
- atomic_i  in  1  qualifies req_i: 1 = start atomic read (snapshot), 0 = next beat.
- ack_o  out  1  read data valid, one cycle after the accepted req_i.
- count_o  out  BUS_W  read data beat; 0 when ack_o low.
- beat_o  out  max(1,$clog2(BEATS))  index of beat on count_o (0 = LSBs).
- last_o  out  1  high with ack_o on beat BEATS-1.
- ovf_o  out  1  sticky overflow flag.

Behaviour:
- Reset: counter=0, snapshot=0, FSM=IDLE, beat index=0, ack_o=0, count_o=0, beat_o=0, last_o=0, ovf_o=0. rst overrides every other input. rst during an in-progress read aborts it; no ack_o follows.
- Counter update priority:
  - clr_i: counter<=0 and ovf_o<=0, even if trig_i is high.
  - else trig_i: counter<=counter+1.
  - At all-ones with trig_i: SATURATE=0 wraps to 0; SATURATE=1 holds all-ones. ovf_o<=1 in both modes.
- Snapshot: captures the registered counter value present at the sampling edge, i.e. before any same-cycle increment or clear.
- Read latency: req_i sampled at edge N gives ack_o, count_o, beat_o and last_o valid during cycle N+1, for exactly one cycle. Back-to-back req_i gives back-to-back ack_o.
- FSM states:
  - IDLE:
    - req_i & atomic_i: snapshot<=counter; return beat 0 of the live counter (same value as snapshot[BUS_W-1:0]); go to BUSY, idx=1.
    - req_i & ~atomic_i: non-atomic read; return live counter beat 0; no snapshot; stay IDLE.
  - BUSY:
    - req_i & ~atomic_i: return snapshot beat idx (bits idx*BUS_W +: BUS_W); idx++. If idx was BEATS-1, assert last_o and go to IDLE.
    - req_i & atomic_i: abort; take a new snapshot, return its beat 0, idx=1, stay BUSY.
    - No req_i: hold state indefinitely; no timeout.
- clr_i during BUSY does not alter the snapshot; remaining beats return the pre-clear value.
- ack_o is never asserted without a request accepted on the previous edge.

Test Plan:
- Reset check (64/32): rst high 2 cycles, then 5 trig_i pulses, then atomic read (req_i+atomic_i, then req_i twice). Expect ack_o on 2 consecutive cycles with count_o=5 then 0, beat_o 0 then 1, last_o on the second beat, FSM back in IDLE. The third req_i is a non-atomic read returning 5.
- Coherence (COUNT_W=8, BUS_W=4): count to 0x0F, hold trig_i high, atomic read. Beats return 0xF then 0x0 although the live counter reaches 0x11 by beat 1.
- Wrap vs saturate (8/4): 256 trig_i from 0. SATURATE=0 gives count 0x00 with ovf_o=1; SATURATE=1 gives count 0xFF with ovf_o=1. A further clr_i gives count 0 and ovf_o=0.
- clr_i and trig_i in the same cycle at count 7: next value is 0.
- Abort/restart (64/32, count=0x1_0000_0003): atomic read beat 0 (returns 3), 4 trig_i pulses, new atomic request. Returns 7 with beat_o=0. The following beat returns 0x1 and asserts last_o.
- Reset mid-read: rst asserted after beat 0 of an atomic read. No further ack_o; the next req_i with atomic_i=0 is non-atomic and returns live beat 0 = 0.
